// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus arbiter.
//   arb_state_t : arbiter FSM states
//   BUS_IDLE_*  : levels driven onto the slave bus when no master owns it
//   id_width()  : master-index width, never below one bit
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  localparam logic BUS_IDLE_CONTROL = 1'b0;
  localparam logic BUS_IDLE_WRD     = 1'b0;
  localparam logic BUS_IDLE_VALID   = 1'b0;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward from i_last+1 with wrap-around.
//   i_req   : request vector
//   i_last  : index of the previous owner
//   o_found : any request present
//   o_idx   : selected index (0 when nothing found)
module rr_pick #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = 1
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  int unsigned w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_cand = (32'(i_last) + i) % N;
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = IDW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial slave bus among NUM_MASTERS masters,
// with an idle turnaround gap before every grant.
// Optional build macro ARB_TIMEOUT_EN: adds tenure timeout preemption, the
// TIMEOUT parameter and the timeoutFlag output.
//   clk, rst                  : clock, async active-high reset
//   arbSend / arbCont         : per-master request in / registered grant out
//   mControl, mWrD, mValid    : master bus bits, granted one forwarded to slave
//   control, wrD, valid       : slave bus outputs
//   sRD, sReady / mRD, mReady : slave response, routed to the owner only
//   busy, grantId             : arbiter status
//   timeoutFlag               : sticky per-master preemption flag (macro only)
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
`ifdef ARB_TIMEOUT_EN
  parameter  int unsigned TIMEOUT     = 256,
`endif
  parameter  int unsigned GAP_CYCLES  = 2,
  localparam int unsigned IDW         = id_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] arbSend,
  output logic [NUM_MASTERS-1:0] arbCont,
  input  logic [NUM_MASTERS-1:0] mControl,
  input  logic [NUM_MASTERS-1:0] mWrD,
  input  logic [NUM_MASTERS-1:0] mValid,
  output logic                   control,
  output logic                   wrD,
  output logic                   valid,
  input  logic                   sRD,
  input  logic                   sReady,
  output logic [NUM_MASTERS-1:0] mRD,
  output logic [NUM_MASTERS-1:0] mReady,
`ifdef ARB_TIMEOUT_EN
  output logic [NUM_MASTERS-1:0] timeoutFlag,
`endif
  output logic                   busy,
  output logic [IDW-1:0]         grantId
);

  localparam int unsigned GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_arb_cont;
  logic [IDW-1:0]         r_grant_id;
  logic [IDW-1:0]         r_last_grant;
  logic [GCW-1:0]         r_gap_cnt;
  logic                   r_busy;

  logic                   w_found;
  logic [IDW-1:0]         w_pick;
  logic [NUM_MASTERS-1:0] w_owner_oh;

  assign w_owner_oh = NUM_MASTERS'(1) << r_grant_id;

  rr_pick #(
    .N   (NUM_MASTERS),
    .IDW (IDW)
  ) u_rr_pick (
    .i_req   (arbSend),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TCW-1:0]         r_ten_cnt;
  logic [NUM_MASTERS-1:0] r_timeout_flag;
  logic                   w_ten_done;
  logic                   w_others;

  assign w_ten_done  = (r_ten_cnt == TCW'(TIMEOUT - 1));
  assign w_others    = |(arbSend & ~w_owner_oh);
  assign timeoutFlag = r_timeout_flag;
`endif

  // Arbitration FSM; all status and grant outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_arb_cont   <= '0;
      r_grant_id   <= '0;
      r_last_grant <= IDW'(NUM_MASTERS - 1);
      r_gap_cnt    <= '0;
      r_busy       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_ten_cnt      <= '0;
      r_timeout_flag <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      // Tenure counter saturates at TIMEOUT-1 when nobody else waits
      if (r_state != GRANT) begin
        r_ten_cnt <= '0;
      end else if (!w_ten_done) begin
        r_ten_cnt <= r_ten_cnt + TCW'(1);
      end
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!arbSend[i]) r_timeout_flag[i] <= 1'b0;
      end
`endif
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_busy     <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state    <= GRANT;
              r_arb_cont <= NUM_MASTERS'(1) << w_pick;
            end else begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          // Pending owner gave up before the grant: abandon silently
          if (!arbSend[r_grant_id]) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_gap_cnt == GCW'(GAP_LAST)) begin
            r_state    <= GRANT;
            r_arb_cont <= w_owner_oh;
          end else begin
            r_gap_cnt <= r_gap_cnt + GCW'(1);
          end
        end
        GRANT: begin
          if (!arbSend[r_grant_id]) begin
            r_state      <= IDLE;
            r_arb_cont   <= '0;
            r_last_grant <= r_grant_id;
            r_busy       <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_ten_done && w_others) begin
            r_state                    <= IDLE;
            r_arb_cont                 <= '0;
            r_last_grant               <= r_grant_id;
            r_busy                     <= 1'b0;
            r_timeout_flag[r_grant_id] <= 1'b1;
          end
`endif
        end
        default: begin
          r_state    <= IDLE;
          r_arb_cont <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign arbCont = r_arb_cont;
  assign busy    = r_busy;
  assign grantId = r_grant_id;

  // Bus routing follows the owner only while the grant is active
  always_comb begin
    control = BUS_IDLE_CONTROL;
    wrD     = BUS_IDLE_WRD;
    valid   = BUS_IDLE_VALID;
    mRD     = '0;
    mReady  = '0;
    if (r_state == GRANT) begin
      control = mControl[r_grant_id];
      wrD     = mWrD[r_grant_id];
      valid   = mValid[r_grant_id];
      mRD     = w_owner_oh & {NUM_MASTERS{sRD}};
      mReady  = w_owner_oh & {NUM_MASTERS{sReady}};
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
module tb_serial_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] arbSend;
  logic [1:0] arbCont;
  logic [1:0] mControl;
  logic [1:0] mWrD;
  logic [1:0] mValid;
  logic       control;
  logic       wrD;
  logic       valid;
  logic       sRD;
  logic       sReady;
  logic [1:0] mRD;
  logic [1:0] mReady;
  logic       busy;
  logic [0:0] grantId;
`ifdef ARB_TIMEOUT_EN
  logic [1:0] timeoutFlag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_bus_arbiter #(
    .NUM_MASTERS (2),
`ifdef ARB_TIMEOUT_EN
    .TIMEOUT     (16),
`endif
    .GAP_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arbSend     (arbSend),
    .arbCont     (arbCont),
    .mControl    (mControl),
    .mWrD        (mWrD),
    .mValid      (mValid),
    .control     (control),
    .wrD         (wrD),
    .valid       (valid),
    .sRD         (sRD),
    .sReady      (sReady),
    .mRD         (mRD),
    .mReady      (mReady),
`ifdef ARB_TIMEOUT_EN
    .timeoutFlag (timeoutFlag),
`endif
    .busy        (busy),
    .grantId     (grantId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arbSend = 2'b11;
    mControl = 2'b11; mWrD = 2'b11; mValid = 2'b11; sRD = 1'b1; sReady = 1'b1;
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL reset_arbCont got=%b exp=00", arbCont); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (grantId !== 1'b0) begin n_fail++; $display("FAIL reset_grantId got=%b exp=0", grantId); end
    n_checks++; if ({control, wrD, valid} !== 3'b000) begin n_fail++; $display("FAIL reset_bus got=%b exp=000", {control, wrD, valid}); end
    n_checks++; if ({mRD, mReady} !== 4'b0000) begin n_fail++; $display("FAIL reset_resp got=%b exp=0000", {mRD, mReady}); end
`ifdef ARB_TIMEOUT_EN
    n_checks++; if (timeoutFlag !== 2'b00) begin n_fail++; $display("FAIL reset_flag got=%b exp=00", timeoutFlag); end
`endif
    rst = 1'b0;
    tick();
    n_checks++; if (arbCont !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL lat_edge1 got=%b/%b exp=00/1", arbCont, busy); end
    tick();
    n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL lat_edge2 got=%b exp=00", arbCont); end
    tick();
    n_checks++; if (arbCont !== 2'b01) begin n_fail++; $display("FAIL lat_edge3 got=%b exp=01", arbCont); end
    n_checks++; if (grantId !== 1'b0) begin n_fail++; $display("FAIL lat_grantId got=%b exp=0", grantId); end
  endtask

  // Master 0 owns the bus; master 1's opposite-valued bits must never leak
  task automatic test_routing();
    logic [2:0] pat;
    pat = 3'b101;
    sReady = 1'b1; sRD = 1'b1; mValid = 2'b01; mWrD = 2'b10;
    for (int i = 0; i < 3; i++) begin
      mControl = {~pat[i], pat[i]};
      #1;
      n_checks++; if (control !== pat[i]) begin n_fail++; $display("FAIL route_control[%0d] got=%b exp=%b", i, control, pat[i]); end
      tick();
    end
    n_checks++; if (valid !== 1'b1 || wrD !== 1'b0) begin n_fail++; $display("FAIL route_valid_wrd got=%b%b exp=10", valid, wrD); end
    n_checks++; if (mReady !== 2'b01) begin n_fail++; $display("FAIL route_mReady got=%b exp=01", mReady); end
    n_checks++; if (mRD !== 2'b01) begin n_fail++; $display("FAIL route_mRD got=%b exp=01", mRD); end
    arbSend = 2'b00; mControl = 2'b11; mValid = 2'b11;
    tick();
    n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL release_arbCont got=%b exp=00", arbCont); end
    n_checks++; if ({control, valid, mReady, mRD} !== 6'b0) begin n_fail++; $display("FAIL release_bus got=%b exp=000000", {control, valid, mReady, mRD}); end
  endtask

  task automatic test_gap_abort();
    arbSend = 2'b10;
    tick();
    n_checks++; if (busy !== 1'b1 || grantId !== 1'b1) begin n_fail++; $display("FAIL abort_pending got=%b/%b exp=1/1", busy, grantId); end
    arbSend = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL abort_nopulse[%0d] got=%b exp=00", i, arbCont); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    arbSend = 2'b01;
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b01) begin n_fail++; $display("FAIL abort_next_grant got=%b exp=01", arbCont); end
    arbSend = 2'b00;
    tick();
  endtask

  // Last owner is master 0, so alternation starts with master 1
  task automatic test_back_to_back();
    logic [1:0] exp_oh;
    int         low_cnt;
    int         g;
    exp_oh = 2'b10;
    arbSend = 2'b11;
    low_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 1 : 0;
      exp_oh = (g == 1) ? 2'b10 : 2'b01;
      for (int w = 0; w < 20; w++) begin
        tick();
        n_checks++; if (arbCont === 2'b11) begin n_fail++; $display("FAIL b2b_multihot got=%b exp=not 11", arbCont); end
        if (arbCont !== 2'b00) break;
        low_cnt++;
      end
      n_checks++; if (arbCont !== exp_oh) begin n_fail++; $display("FAIL b2b_owner[%0d] got=%b exp=%b", k, arbCont, exp_oh); end
      if (k > 0) begin
        n_checks++; if (low_cnt < 3) begin n_fail++; $display("FAIL b2b_gap[%0d] got=%0d exp>=3", k, low_cnt); end
      end
      repeat (9) begin
        tick();
        n_checks++; if (arbCont !== exp_oh) begin n_fail++; $display("FAIL b2b_hold[%0d] got=%b exp=%b", k, arbCont, exp_oh); end
      end
      arbSend[g] = 1'b0;
      tick();
      n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL b2b_release[%0d] got=%b exp=00", k, arbCont); end
      low_cnt = 1;
      if (k < 3) arbSend[g] = 1'b1;
      else arbSend = 2'b00;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    arbSend = 2'b10; mControl = 2'b10; mValid = 2'b10;
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b10) begin n_fail++; $display("FAIL mid_grant1 got=%b exp=10", arbCont); end
    n_checks++; if ({control, valid} !== 2'b11) begin n_fail++; $display("FAIL mid_bus_before got=%b exp=11", {control, valid}); end
    arbSend = 2'b11;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (arbCont !== 2'b00) begin n_fail++; $display("FAIL mid_async_arbCont got=%b exp=00", arbCont); end
    n_checks++; if ({control, valid} !== 2'b00) begin n_fail++; $display("FAIL mid_async_bus got=%b exp=00", {control, valid}); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b01) begin n_fail++; $display("FAIL mid_regrant got=%b exp=01", arbCont); end
    arbSend = 2'b00;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int high_cnt;
    arbSend = 2'b01;
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b01) begin n_fail++; $display("FAIL to_grant0 got=%b exp=01", arbCont); end
    high_cnt = 1;
    repeat (4) begin tick(); high_cnt++; end
    arbSend = 2'b11;
    for (int w = 0; w < 40; w++) begin
      tick();
      if (arbCont !== 2'b01) break;
      high_cnt++;
    end
    n_checks++; if (high_cnt !== 16) begin n_fail++; $display("FAIL to_tenure got=%0d exp=16", high_cnt); end
    n_checks++; if (timeoutFlag !== 2'b01) begin n_fail++; $display("FAIL to_flag_set got=%b exp=01", timeoutFlag); end
    repeat (3) tick();
    n_checks++; if (arbCont !== 2'b10) begin n_fail++; $display("FAIL to_grant1 got=%b exp=10", arbCont); end
    n_checks++; if (timeoutFlag !== 2'b01) begin n_fail++; $display("FAIL to_flag_sticky got=%b exp=01", timeoutFlag); end
    arbSend = 2'b10;
    tick();
    n_checks++; if (timeoutFlag !== 2'b00) begin n_fail++; $display("FAIL to_flag_clear got=%b exp=00", timeoutFlag); end
    arbSend = 2'b00;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_gap_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
